// File: rtl/issue_controller_pkg.sv
// Shared constants for the dual-issue sequencer: bubble words, stop opcode and FSM encodings.
package issue_controller_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h4020_0000;
    localparam logic [31:0] LNOP_WORD = 32'h0020_0000;
    // Compared against the top 11 bits of an instruction word.
    localparam logic [10:0] STOP_OPC  = 11'h000;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_SPLIT     = 2'd1;
    localparam logic [1:0] ST_ODD_ENTRY = 2'd2;
    localparam logic [1:0] ST_HALT      = 2'd3;

    function automatic logic is_stop_opc(input logic [10:0] opc);
        return opc == STOP_OPC;
    endfunction

endpackage

// File: rtl/issue_controller_slot_router.sv
// Steers one instruction word into the even or odd slot; the unused slot carries its bubble.
module issue_controller_slot_router
    import issue_controller_pkg::*;
#(
    parameter int unsigned INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] word_i,
    input  logic               type_i,
    input  logic               valid_i,
    output logic [INSTR_W-1:0] even_o,
    output logic [INSTR_W-1:0] odd_o,
    output logic               even_vld_o,
    output logic               odd_vld_o
);

    always_comb begin
        even_o     = INSTR_W'(NOP_WORD);
        odd_o      = INSTR_W'(LNOP_WORD);
        even_vld_o = 1'b0;
        odd_vld_o  = 1'b0;
        if (valid_i) begin
            if (type_i) begin
                odd_o     = word_i;
                odd_vld_o = 1'b1;
            end else begin
                even_o     = word_i;
                even_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_controller.sv
// Dual-issue sequencer between fetch and decode: owns the PC, splits hazardous pairs,
// handles branch redirects (including odd-word entry) and halts on stop.
module issue_controller
    import issue_controller_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_valid,
    input  logic [INSTR_W-1:0] instr1,
    input  logic [INSTR_W-1:0] instr2,
    input  logic               instr1_type,
    input  logic               instr2_type,
    input  logic               stall,
    input  logic               dependent_stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    fetch_pc,
    output logic [INSTR_W-1:0] issue_even,
    output logic [INSTR_W-1:0] issue_odd,
    output logic               issue_even_vld,
    output logic               issue_odd_vld,
    output logic               halted
);

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] even_q, even_d, odd_q, odd_d;
    logic               even_vld_q, even_vld_d, odd_vld_q, odd_vld_d;
    logic               sel1, sel2;
    logic               stop1, stop2;

    logic [INSTR_W-1:0] r1_even, r1_odd, r2_even, r2_odd;
    logic               r1_even_vld, r1_odd_vld, r2_even_vld, r2_odd_vld;

    // Word-alignment bits of the target are architecturally ignored.
    logic unused_bt;
    assign unused_bt = ^branch_target[1:0];

    assign stop1 = is_stop_opc(instr1[INSTR_W-1 -: 11]);
    assign stop2 = is_stop_opc(instr2[INSTR_W-1 -: 11]);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sel1    = 1'b0;
        sel2    = 1'b0;
        if (state_q == ST_HALT) begin
            state_d = ST_HALT;
        end else if (flush) begin
            pc_d    = {branch_target[PC_W-1:3], 3'b000};
            state_d = branch_target[2] ? ST_ODD_ENTRY : ST_RUN;
        end else if (!stall && fetch_valid) begin
            if (state_q == ST_SPLIT || state_q == ST_ODD_ENTRY) begin
                sel2    = 1'b1;
                pc_d    = pc_q + PC_W'(8);
                state_d = stop2 ? ST_HALT : ST_RUN;
            end else if (dependent_stall || (instr1_type == instr2_type) || stop1) begin
                // A stop in the first word also takes this path; its partner is never issued.
                sel1    = 1'b1;
                state_d = stop1 ? ST_HALT : ST_SPLIT;
            end else begin
                sel1    = 1'b1;
                sel2    = 1'b1;
                pc_d    = pc_q + PC_W'(8);
                state_d = stop2 ? ST_HALT : ST_RUN;
            end
        end
    end

    issue_controller_slot_router #(.INSTR_W(INSTR_W)) u_route1 (
        .word_i     (instr1),
        .type_i     (instr1_type),
        .valid_i    (sel1),
        .even_o     (r1_even),
        .odd_o      (r1_odd),
        .even_vld_o (r1_even_vld),
        .odd_vld_o  (r1_odd_vld)
    );

    issue_controller_slot_router #(.INSTR_W(INSTR_W)) u_route2 (
        .word_i     (instr2),
        .type_i     (instr2_type),
        .valid_i    (sel2),
        .even_o     (r2_even),
        .odd_o      (r2_odd),
        .even_vld_o (r2_even_vld),
        .odd_vld_o  (r2_odd_vld)
    );

    // Co-issued words always have opposite types, so the two routers never collide.
    always_comb begin
        even_d     = r1_even_vld ? r1_even : r2_even;
        odd_d      = r1_odd_vld ? r1_odd : r2_odd;
        even_vld_d = r1_even_vld | r2_even_vld;
        odd_vld_d  = r1_odd_vld | r2_odd_vld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= '0;
            even_q     <= INSTR_W'(NOP_WORD);
            odd_q      <= INSTR_W'(LNOP_WORD);
            even_vld_q <= 1'b0;
            odd_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            even_q     <= even_d;
            odd_q      <= odd_d;
            even_vld_q <= even_vld_d;
            odd_vld_q  <= odd_vld_d;
        end
    end

    assign fetch_pc       = pc_q;
    assign issue_even     = even_q;
    assign issue_odd      = odd_q;
    assign issue_even_vld = even_vld_q;
    assign issue_odd_vld  = odd_vld_q;
    assign halted         = (state_q == ST_HALT);

endmodule
